multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle RISC-V control decoder. A Moore finite-state machine (FSM) sequences fetch, decode, execute, memory and writeback over several clocks, and drives the shared-memory multicycle datapath. An ALU sub-decoder handles R/I-type ALU ops, including correct SUB/XOR and BEQ/BNE handling. It adds a memory-ready stall handshake, a sticky illegal-opcode trap and a retired-instruction counter.

---
 rtl/multicycle_control_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Control unit for the shared-memory multicycle RISC-V datapath: a Moore FSM with an ALU
// sub-decoder, mem_ready stalls, a sticky illegal-opcode trap and a retired-instruction counter.
module multicycle_control_unit #(
  parameter bit WAIT_EN = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero_flg,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             RegWrite,
  output logic             illegal_instr,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t           state_reg;
  state_t           state_next;
  logic             illegal_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [6:0] op;
  logic [2:0] f3;
  logic       f7b5;
  logic       rdy;
  logic       retire;
  logic [1:0] alu_op;
  logic       pc_write_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       unused_instr_bits;

  assign op   = instr[6:0];
  assign f3   = instr[14:12];
  assign f7b5 = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // With stalls disabled every memory access is treated as completing immediately.
  assign rdy = WAIT_EN ? mem_ready : 1'b1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    if (rdy) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_JAL:            state_next = S_JAL;
          OP_BRANCH:         state_next = S_BRANCH;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (rdy) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (rdy) state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_JAL:      state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
  end

  // An instruction retires on the final edge of its sequence back to FETCH.
  assign retire = (state_reg == S_MEMWB) || (state_reg == S_ALUWB) ||
                  (state_reg == S_BRANCH) || ((state_reg == S_MEMWRITE) && rdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      illegal_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next == S_TRAP) illegal_reg <= 1'b1;
      if (retire) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    AdrSrc        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = 2'b00;
    reg_write_raw = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = rdy;
        pc_write_raw = rdy;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_JAL: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pc_write_raw = 1'b1;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_BRANCH: begin
        // f3[0] flips the sense: BEQ takes on zero, BNE on non-zero.
        ALUSrcA      = 2'b10;
        alu_op       = 2'b01;
        pc_write_raw = zero_flg ^ f3[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      2'b01: ALUControl = ALU_SUB;
      2'b10: begin
        case (f3)
          // op[5] separates R-type from I-type so ADDI with instr[30] set stays ADD.
          3'b000:  ALUControl = (op[5] & f7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b100:  ALUControl = ALU_XOR;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

  // Write enables are killed combinationally so reset takes effect before any edge.
  assign PCWrite  = pc_write_raw  & ~rst;
  assign IRWrite  = ir_write_raw  & ~rst;
  assign MemWrite = mem_write_raw & ~rst;
  assign RegWrite = reg_write_raw & ~rst;

  assign illegal_instr = illegal_reg;
  assign state_o       = state_reg;
  assign retired_cnt   = cnt_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: per-instruction state paths and control words
// from a reference model, plus directed reset, no-stall and counter-wrap scenarios.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_nw = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        zero_flg = 1'b0;
  logic        mem_ready = 1'b0;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;
  logic [3:0] retired_cnt;

  logic        nw_pc_write, nw_adr_src, nw_mem_write, nw_ir_write, nw_reg_write, nw_illegal;
  logic [1:0]  nw_result_src, nw_alu_src_a, nw_alu_src_b, nw_imm_src;
  logic [2:0]  nw_alu_control;
  logic [3:0]  nw_state_o;
  logic [31:0] nw_retired_cnt;

  multicycle_control_unit #(.WAIT_EN(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero_flg(zero_flg), .mem_ready(mem_ready),
    .PCWrite(pc_write), .AdrSrc(adr_src), .MemWrite(mem_write), .IRWrite(ir_write),
    .ResultSrc(result_src), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ImmSrc(imm_src),
    .ALUControl(alu_control), .RegWrite(reg_write), .illegal_instr(illegal_instr),
    .state_o(state_o), .retired_cnt(retired_cnt)
  );

  multicycle_control_unit #(.WAIT_EN(1'b0), .CNT_W(32)) dut_nw (
    .clk(clk), .rst(rst_nw), .instr(instr), .zero_flg(zero_flg), .mem_ready(mem_ready),
    .PCWrite(nw_pc_write), .AdrSrc(nw_adr_src), .MemWrite(nw_mem_write), .IRWrite(nw_ir_write),
    .ResultSrc(nw_result_src), .ALUSrcA(nw_alu_src_a), .ALUSrcB(nw_alu_src_b), .ImmSrc(nw_imm_src),
    .ALUControl(nw_alu_control), .RegWrite(nw_reg_write), .illegal_instr(nw_illegal),
    .state_o(nw_state_o), .retired_cnt(nw_retired_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: the list of states an instruction walks through, and a cursor into it.
  int path[6];
  int plen;
  int idx;
  int model_cnt;
  bit need_instr;
  int trap_cycles;
  int lw_seq[5] = '{1, 2, 3, 4, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1101111 || op == 7'b1100011;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  op;
    int k;
    w = $urandom;
    k = $urandom_range(0, 30);
    if      (k < 5)  op = 7'b0000011;
    else if (k < 10) op = 7'b0100011;
    else if (k < 15) op = 7'b0110011;
    else if (k < 20) op = 7'b0010011;
    else if (k < 24) op = 7'b1101111;
    else if (k < 30) op = 7'b1100011;
    else begin
      op = 7'($urandom);
      while (is_legal(op)) op = 7'($urandom);
    end
    return {w[31:7], op};
  endfunction

  task automatic set_path(input logic [31:0] ins);
    path = '{0, 1, 11, 0, 0, 0};
    plen = 3;
    case (ins[6:0])
      7'b0000011: begin path = '{0, 1, 2, 3, 4, 0}; plen = 5; end
      7'b0100011: begin path = '{0, 1, 2, 5, 0, 0}; plen = 4; end
      7'b0110011: begin path = '{0, 1, 6, 7, 0, 0}; plen = 4; end
      7'b0010011: begin path = '{0, 1, 8, 7, 0, 0}; plen = 4; end
      7'b1101111: begin path = '{0, 1, 9, 7, 0, 0}; plen = 4; end
      7'b1100011: begin path = '{0, 1, 10, 0, 0, 0}; plen = 3; end
      default: ;
    endcase
  endtask

  // ALU function for a register/immediate arithmetic instruction, by its funct3 meaning.
  function automatic logic [2:0] arith_fn(input logic [2:0] f3, input bit is_sub);
    case (f3)
      3'b000:  return is_sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Control word {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,RegWrite}.
  function automatic logic [15:0] exp_ctrl(input int st, input logic [31:0] ins,
                                           input logic z, input logic r);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    rs = 0; sa = 0; sb = 0; alu = 3'b000;
    if      (ins[6:0] == 7'b0100011) imm = 2'b01;
    else if (ins[6:0] == 7'b1100011) imm = 2'b10;
    else if (ins[6:0] == 7'b1101111) imm = 2'b11;
    else                             imm = 2'b00;
    case (st)
      0:  begin sb = 2; rs = 2; irw = r; pcw = r; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; sb = 0; alu = arith_fn(ins[14:12], ins[30]); end
      7:  rw = 1;
      8:  begin sa = 2; sb = 1; alu = arith_fn(ins[14:12], 1'b0); end
      9:  begin sa = 1; sb = 2; pcw = 1; end
      10: begin sa = 2; alu = 3'b001; pcw = ins[12] ? !z : z; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw};
  endfunction

  initial begin
    int cur;
    mem_ready = 1'b1;
    instr = 32'h00452283;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_cnt", 32'(retired_cnt), 32'd0);
    chk("rst_illegal", 32'(illegal_instr), 32'd0);
    chk("rst_we_forced", 32'({pc_write, ir_write, mem_write, reg_write}), 32'd0);
    rst = 1'b0;
    idx = 0; model_cnt = 0; need_instr = 1; trap_cycles = 0;

    for (int cyc = 0; cyc < 2500; cyc++) begin
      if (need_instr) begin
        instr = gen_instr();
        set_path(instr);
        need_instr = 0;
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      zero_flg = 1'($urandom_range(0, 1));
      #1;
      chk("state", 32'(state_o), 32'(path[idx]));
      chk("ctrl", 32'({pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                       alu_src_b, imm_src, alu_control, reg_write}),
          32'(exp_ctrl(path[idx], instr, zero_flg, mem_ready)));
      chk("retired_cnt", 32'(retired_cnt), 32'(model_cnt % 16));
      chk("illegal", 32'(illegal_instr), 32'(path[idx] == 11));
      if (path[idx] == 11) begin
        trap_cycles++;
        if (trap_cycles == 3) begin
          rst = 1'b1;
          #1;
          chk("trap_rst_state", 32'(state_o), 32'd0);
          chk("trap_rst_illegal", 32'(illegal_instr), 32'd0);
          chk("trap_rst_cnt", 32'(retired_cnt), 32'd0);
          $display("trap instr=%h op=%b cleared by reset", instr, instr[6:0]);
          @(posedge clk);
          @(negedge clk);
          rst = 1'b0;
          idx = 0; model_cnt = 0; need_instr = 1; trap_cycles = 0;
          continue;
        end
      end
      @(posedge clk);
      cur = path[idx];
      if (cur == 11) begin
      end else if ((cur == 0 || cur == 3 || cur == 5) && !mem_ready) begin
      end else begin
        idx++;
        if (idx == plen) begin
          model_cnt++;
          $display("retired instr=%h op=%b cnt=%0d", instr, instr[6:0], model_cnt % 16);
          idx = 0;
          need_instr = 1;
        end
      end
      @(negedge clk);
    end

    // WAIT_EN = 0: lw completes with mem_ready held low.
    rst = 1'b1;
    rst_nw = 1'b0;
    mem_ready = 1'b0;
    instr = 32'h00452283;
    #1;
    chk("nw_state", 32'(nw_state_o), 32'd0);
    chk("nw_ctrl", 32'({nw_pc_write, nw_adr_src, nw_mem_write, nw_ir_write, nw_result_src,
                        nw_alu_src_a, nw_alu_src_b, nw_imm_src, nw_alu_control, nw_reg_write}),
        32'(exp_ctrl(0, instr, zero_flg, 1'b1)));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("nw_state", 32'(nw_state_o), 32'(lw_seq[i]));
      chk("nw_ctrl", 32'({nw_pc_write, nw_adr_src, nw_mem_write, nw_ir_write, nw_result_src,
                          nw_alu_src_a, nw_alu_src_b, nw_imm_src, nw_alu_control, nw_reg_write}),
          32'(exp_ctrl(lw_seq[i], instr, zero_flg, 1'b1)));
    end
    chk("nw_cnt", nw_retired_cnt, 32'd1);
    chk("nw_illegal", 32'(nw_illegal), 32'd0);
    $display("no-stall lw retired cnt=%0d", nw_retired_cnt);

    // Asynchronous reset while a store is stalled in MEMWRITE.
    @(negedge clk);
    rst = 1'b0;
    instr = 32'h00A12223;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("sw_state", 32'(state_o), 32'd5);
    chk("sw_memwrite", 32'(mem_write), 32'd1);
    @(negedge clk); #1;
    chk("sw_stall_state", 32'(state_o), 32'd5);
    chk("sw_stall_memwrite", 32'(mem_write), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_memwrite", 32'(mem_write), 32'd0);
    chk("async_rst_state", 32'(state_o), 32'd0);
    $display("store stalled then reset asynchronously");

    // Counter wrap: 16 branches on the 4-bit counter.
    @(negedge clk);
    rst = 1'b0;
    instr = 32'h00000063;
    mem_ready = 1'b1;
    zero_flg = 1'b1;
    repeat (45) @(posedge clk);
    #1;
    chk("cnt_15", 32'(retired_cnt), 32'd15);
    chk("cnt_15_state", 32'(state_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("cnt_wrap", 32'(retired_cnt), 32'd0);
    $display("16 branches retired, counter wrapped to %0d", retired_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
